multi_flux_fifo: RTL
====================

// Module: multi_flux_fifo
// PURPOSE
//  FIFO end of the write/read actor protocol: sits between a producer actor and a consumer actor (e.g. shift) in the HEVC dataflow.
//  Holds FLUX independent queues, one per data flux, sharing one write port and one read port.
//  Consumer sees per-flux empty, producer sees per-flux full; consumer data is show-ahead so actors consume in the same cycle.
// PARAMETERS
//  FLUX        2   number of independent data fluxes (queues), >=1
//  DATA_WIDTH  32  width of one token
//  DEPTH       8   tokens per flux queue, power of two, >=2
//  TAG_WIDTH   $clog2(FLUX) (min 1)  flux index width; derived, not overridden
// PORTS
//  clk            in   1           single clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  wr_write       in   1           push request from producer
//  wr_tag         in   TAG_WIDTH   flux index targeted by push
//  wr_din         in   DATA_WIDTH  token to push
//  wr_full        out  FLUX        bit i = flux i holds DEPTH tokens
//  rd_read        in   FLUX        pop request, one-hot by protocol
//  rd_dout        out  DATA_WIDTH  head token of selected flux (combinational)
//  rd_empty       out  FLUX        bit i = flux i holds 0 tokens
//  err_overflow   out  1           sticky: push to full flux or wr_tag>=FLUX
//  err_underflow  out  1           sticky: pop of empty flux or rd_read not one-hot
// BEHAVIOUR
//  - Reset (async assert, sync release): all counts/pointers 0; rd_empty='1; wr_full='0; errors 0; storage contents not reset.
//  - Per flux i: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH, $clog2(DEPTH)+1 bits).
//  - rd_empty[i] = (count==0); wr_full[i] = (count==DEPTH); both purely registered-state derived, no input dependence.
//  - Push: wr_write & wr_tag<FLUX & !wr_full[wr_tag] -> mem[tag][wr_ptr]<=wr_din, wr_ptr++, count++ at next edge.
//  - Pop: lowest index i with rd_read[i] & !rd_empty[i] -> rd_ptr++, count-- at next edge.
//  - rd_dout: head (mem[i][rd_ptr]) of lowest-index flux with rd_read set; if rd_read==0, head of lowest-index non-empty flux;
//    '0 if selected flux empty. Path rd_read->rd_dout is combinational, zero latency (show-ahead).
//  - Latency: token pushed at edge N is visible on rd_dout / rd_empty deasserted after edge N; no fall-through in the same cycle.
//  - Simultaneous push+pop, same flux, 0<count<DEPTH: both happen, count unchanged.
//  - Push to full flux: dropped even if same flux popped that cycle; state unchanged; err_overflow<=1.
//  - Pop of empty flux: ignored, even if same flux pushed that cycle; err_underflow<=1.
//  - wr_tag>=FLUX (non-power-of-two FLUX): push dropped, err_overflow<=1.
//  - rd_read with >1 bit set: only lowest-index bit honoured; err_underflow<=1.
//  - Pointer wrap: DEPTH-1 -> 0 with no bubble; full and empty distinguished by count, not pointer equality.
//  - Error flags clear only on rst.
//  - Reset mid-operation: all fluxes empty immediately on rst assert; outputs follow asynchronously.
// STRUCTURE
//  - fifo_pkg: flux_tag_t width function, DEPTH/width helper functions, shared by actors and FIFOs.
//  - Sub-module flux_queue (one per flux, generate loop): storage, pointers, count, full/empty, push_en/pop_en inputs, head output.
//  - Top: push decode by wr_tag, pop priority select over rd_read, rd_dout mux, error flag logic.
// TESTING
//  1 Reset: hold rst mid-run with flux0 holding 3 tokens -> rd_empty=2'b11, wr_full=2'b00, errors 0, rd_dout=0.
//  2 Push 0x11,0x22,0x33 to flux1, pop 3 via rd_read=2'b10 -> rd_dout 0x11,0x22,0x33 in order; rd_empty[1] back to 1.
//  3 Fill flux0 with 8 tokens -> wr_full=2'b01; 9th push 0xFF dropped, err_overflow=1; pop all -> original 8 tokens, 0xFF never seen.
//  4 Flux0 count=4, push+pop flux0 same cycle for 20 cycles (pointers wrap) -> count stays 4, data in order, no errors.
//  5 Both fluxes non-empty, rd_read=2'b11 -> only flux0 popped, rd_dout=flux0 head, err_underflow=1; rd_read=2'b01 on empty flux0 -> no change.
//  6 Chain with shift actor, random pushes both fluxes -> every output = input>>11, per-flux order kept, no tokens lost.

Source files
------------

// File: rtl/multi_flux_fifo_pkg.sv
// Shared sizing helpers for the multi-flux FIFO and the actors that talk to it.
package multi_flux_fifo_pkg;

   // Per-queue operation selected in one cycle, encoded as {push, pop}.
   typedef enum logic [1:0] {
      Q_IDLE = 2'b00,
      Q_POP  = 2'b01,
      Q_PUSH = 2'b10,
      Q_BOTH = 2'b11
   } q_op_e;

   // Width of a flux tag. It is never narrower than one bit, so a single-flux FIFO still has a port.
   function automatic int tag_width(input int flux);
      return (flux > 1) ? $clog2(flux) : 1;
   endfunction

   // Width of a read or write pointer inside one queue.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of an occupancy count. One extra bit lets the count reach DEPTH.
   function automatic int cnt_width(input int depth);
      return ptr_width(depth) + 1;
   endfunction

endpackage

// File: rtl/multi_flux_fifo_flux_queue.sv
// One flux queue: circular storage with pointers and an occupancy count.
// The enables arrive already qualified: push_en_i is never set when the queue is full,
// and pop_en_i is never set when it is empty.
module multi_flux_fifo_flux_queue
   import multi_flux_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_en_i,
   input  logic                  pop_en_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic                  empty_o,
   output logic                  full_o
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   q_op_e                 op;

   // Next-state logic for the pointers and the count. DEPTH is a power of two, so the pointers wrap for free.
   always_comb begin
      // NOTE: each variable gets a default before the case statement, so no path can leave it unassigned and infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      op       = q_op_e'({push_en_i, pop_en_i});
      case (op)
         Q_PUSH: begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
         end
         Q_POP: begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
         end
         Q_BOTH: begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         default: ;
      endcase
   end

   // Pointer and count registers. A reset empties the queue immediately.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples its pre-edge inputs.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Token storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is left out of reset on purpose. The count already makes stale entries unreachable.
      if (push_en_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Head and status come only from registered state, so data pushed this cycle cannot fall through.
   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/multi_flux_fifo.sv
// Multi-flux FIFO: FLUX independent queues behind one write port and one show-ahead read port.
// The producer steers each token with wr_tag. The consumer pops with a one-hot rd_read.
module multi_flux_fifo
   import multi_flux_fifo_pkg::*;
#(
   parameter  int FLUX       = 2,
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 8,
   localparam int TAG_WIDTH  = tag_width(FLUX)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_write,
   input  logic [TAG_WIDTH-1:0]  wr_tag,
   input  logic [DATA_WIDTH-1:0] wr_din,
   output logic [FLUX-1:0]       wr_full,
   input  logic [FLUX-1:0]       rd_read,
   output logic [DATA_WIDTH-1:0] rd_dout,
   output logic [FLUX-1:0]       rd_empty,
   output logic                  err_overflow,
   output logic                  err_underflow
);

   logic [FLUX-1:0]       push_en, pop_en;
   logic [DATA_WIDTH-1:0] heads [FLUX];
   logic [TAG_WIDTH-1:0]  rd_sel, nz_sel, out_sel;
   logic                  rd_found, nz_found, read_multi;
   logic                  ovf_evt, unf_evt;
   logic                  err_overflow_q, err_overflow_d;
   logic                  err_underflow_q, err_underflow_d;

   for (genvar g = 0; g < FLUX; g++) begin : g_flux
      multi_flux_fifo_flux_queue #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_queue (
         .clk       (clk),
         .rst       (rst),
         .push_en_i (push_en[g]),
         .pop_en_i  (pop_en[g]),
         .din_i     (wr_din),
         .head_o    (heads[g]),
         .empty_o   (rd_empty[g]),
         .full_o    (wr_full[g])
      );
   end

   // Push decode. A tag that matches no flux, or a push to a full flux, is dropped and counted as an overflow.
   always_comb begin
      push_en = '0;
      for (int i = 0; i < FLUX; i++) begin
         push_en[i] = wr_write && (wr_tag == TAG_WIDTH'(i)) && !wr_full[i];
      end
      ovf_evt = wr_write && (push_en == '0);
   end

   // Pop priority select, show-ahead output mux and underflow detection.
   always_comb begin
      rd_sel   = '0;
      nz_sel   = '0;
      rd_found = 1'b0;
      nz_found = 1'b0;
      pop_en   = '0;
      for (int i = 0; i < FLUX; i++) begin
         if (!rd_found && rd_read[i]) begin
            rd_sel   = TAG_WIDTH'(i);
            rd_found = 1'b1;
         end
         if (!nz_found && !rd_empty[i]) begin
            nz_sel   = TAG_WIDTH'(i);
            nz_found = 1'b1;
         end
      end
      read_multi = (rd_read & (rd_read - FLUX'(1))) != '0;
      if (rd_found) begin
         pop_en[rd_sel] = !rd_empty[rd_sel];
      end
      unf_evt = read_multi || (rd_found && rd_empty[rd_sel]);
      // With no read request the output previews the first non-empty flux.
      out_sel = rd_found ? rd_sel : nz_sel;
      rd_dout = rd_empty[out_sel] ? '0 : heads[out_sel];
   end

   // Sticky error flags. Only reset clears them.
   always_comb begin
      err_overflow_d  = err_overflow_q  | ovf_evt;
      err_underflow_d = err_underflow_q | unf_evt;
   end

   // Error flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign err_overflow  = err_overflow_q;
   assign err_underflow = err_underflow_q;

endmodule
